// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the key debouncer.
// The auto-repeat option is enabled by defining KEY_DEBOUNCE_REPEAT_EN.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int DEF_NKEYS           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_KEY_ACTIVE_LOW  = 1;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    // Counter width that can hold the largest of the three timing targets.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key channel: 2-flop synchroniser, polarity fix, debounce FSM, pulses.
// With KEY_DEBOUNCE_REPEAT_EN defined, a held key also emits auto-repeat press pulses.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW,
`ifdef KEY_DEBOUNCE_REPEAT_EN
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
`endif
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic INV = (KEY_ACTIVE_LOW != 0);

    logic             sync_p0_q, sync_p1_q;
    logic             synced;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             accept_press, accept_release;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // True once the count including the current clock has reached target.
    function automatic logic reached(input logic [CNT_W-1:0] v, input int target);
        return (int'(v) + 1) >= target;
    endfunction

    // Stage p0/p1: synchroniser; synced is 1 while the key is pressed.
    assign synced = sync_p1_q ^ INV;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0_q <= INV;
            sync_p1_q <= INV;
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_p0_q <= key_raw;
            sync_p1_q <= sync_p0_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RELEASED: begin
                if (synced) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!synced)                               state_d = ST_RELEASED;
                else if (reached(cnt_q, DEBOUNCE_CYCLES - 1)) state_d = ST_HELD;
                else                                       cnt_d   = sat_inc(cnt_q);
            end
            ST_HELD: begin
                if (!synced) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (synced)                                state_d = ST_HELD;
                else if (reached(cnt_q, DEBOUNCE_CYCLES - 1)) state_d = ST_RELEASED;
                else                                       cnt_d   = sat_inc(cnt_q);
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    assign accept_press   = (state_q == ST_PRESS_WAIT)   && (state_d == ST_HELD);
    assign accept_release = (state_q == ST_RELEASE_WAIT) && (state_d == ST_RELEASED);

`ifdef KEY_DEBOUNCE_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic             rep_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end

    // Repeat time only advances on stable held clocks; a bounce that
    // returns to HELD resumes where it left off.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if (accept_press || accept_release) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (state_q == ST_HELD && synced) begin
            if (reached(rep_cnt_q, rep_first_q ? REPEAT_DELAY : REPEAT_PERIOD)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = sat_inc(rep_cnt_q);
            end
        end
    end
`endif

    always_comb begin
        level_d   = level_q;
        release_d = accept_release;
        if (accept_press)   level_d = 1'b1;
        if (accept_release) level_d = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        press_d = accept_press || rep_fire;
`else
        press_d = accept_press;
`endif
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: NKEYS independent channels producing level and press/release pulses.
// Define KEY_DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a key is held.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NKEYS           = DEF_NKEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    for (genvar i = 0; i < NKEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
`ifdef KEY_DEBOUNCE_REPEAT_EN
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .key_raw   (key[i]),
            .level_o   (key_level[i]),
            .press_o   (key_press[i]),
            .release_o (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus randomized traffic
// compared against a run-length reference model (honours KEY_DEBOUNCE_REPEAT_EN).
module tb_key_debounce;

    localparam int NKEYS = 4;
    localparam int D     = 8;
    localparam int RD    = 40;
    localparam int RP    = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NKEYS-1:0] key = '1;
    logic [NKEYS-1:0] key_level, key_press, key_release;

    int checks = 0;
    int errors = 0;

    // Reference model: level flips after D consecutive synchronised samples
    // that disagree with it; samples are the raw key delayed by two clocks.
    logic [NKEYS-1:0] m_d1, m_d2, m_lvl, m_press, m_rel;
    int               m_run [NKEYS];
`ifdef KEY_DEBOUNCE_REPEAT_EN
    int               m_rep [NKEYS];
    bit               m_first [NKEYS];
`endif

    key_debounce #(
        .NKEYS           (NKEYS),
        .DEBOUNCE_CYCLES (D),
        .KEY_ACTIVE_LOW  (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        for (int c = 0; c < NKEYS; c++) begin
            logic s;
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            if (rst) begin
                m_d1[c] = 1'b0; m_d2[c] = 1'b0; m_lvl[c] = 1'b0; m_run[c] = 0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                m_rep[c] = 0; m_first[c] = 1'b1;
`endif
            end else begin
                s       = m_d2[c];
                m_d2[c] = m_d1[c];
                m_d1[c] = ~key[c];
                if (s != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_lvl[c] = s;
                        m_run[c] = 0;
                        if (s) m_press[c] = 1'b1;
                        else   m_rel[c]   = 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        m_rep[c] = 0; m_first[c] = 1'b1;
`endif
                    end
                end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
                    if (m_lvl[c] && m_run[c] == 0) begin
                        m_rep[c]++;
                        if (m_rep[c] == (m_first[c] ? RD : RP)) begin
                            m_press[c] = 1'b1;
                            m_rep[c]   = 0;
                            m_first[c] = 1'b0;
                        end
                    end
`endif
                    m_run[c] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key = '1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({key_level, key_press, key_release} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {key_level, key_press, key_release});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release} !== '0) begin
                errors++;
                $display("FAIL reset_exit_quiet: cycle %0d got %h expected 0", i, {key_level, key_press, key_release});
            end
        end
    endtask

    task automatic test_clean_press();
        int np = 0, nr = 0, tp = -1, tr = -1;
        key[0] = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (key_press[0]) begin np++; if (tp < 0) tp = t; end
            if (key_release[0]) nr++;
        end
        checks++;
        if (np !== 1 || tp !== 10) begin
            errors++;
            $display("FAIL clean_press: got %0d pulses first at %0d expected 1 at 10", np, tp);
        end
        checks++;
        if (key_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL clean_level_high: got %b expected 1", key_level[0]);
        end
        key[0] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (key_release[0]) begin nr++; if (tr < 0) tr = t; end
            if (key_press[0]) np++;
        end
        checks++;
        if (nr !== 1 || tr !== 10 || np !== 1) begin
            errors++;
            $display("FAIL clean_release: got %0d rel at %0d, %0d presses expected 1 at 10, 1", nr, tr, np);
        end
        checks++;
        if (key_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_level_low: got %b expected 0", key_level[0]);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0, hi = 0;
        for (int t = 0; t < 30; t++) begin
            if (t % 3 == 0) key[1] = ~key[1];
            tick();
            pulses += key_press[1] + key_release[1];
            hi     += key_level[1];
        end
        key[1] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            pulses += key_press[1] + key_release[1];
            hi     += key_level[1];
        end
        checks++;
        if (pulses !== 0 || hi !== 0) begin
            errors++;
            $display("FAIL bounce_filtered: got %0d pulses %0d level-high clocks expected 0 0", pulses, hi);
        end
    endtask

    task automatic test_simultaneous();
        int t2 = -1, t3 = -1;
        key[3:2] = 2'b00;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (key_press[2] && t2 < 0) t2 = t;
            if (key_press[3] && t3 < 0) t3 = t;
        end
        checks++;
        if (t2 !== 10 || t3 !== 10) begin
            errors++;
            $display("FAIL simultaneous_press: got %0d and %0d expected 10 and 10", t2, t3);
        end
        key[3:2] = 2'b11;
        for (int t = 0; t < 14; t++) tick();
        checks++;
        if (key_level[3:2] !== 2'b00) begin
            errors++;
            $display("FAIL simultaneous_release: got %b expected 00", key_level[3:2]);
        end
    endtask

    task automatic test_reset_mid();
        int np = 0, tp = -1;
        key[0] = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            np += key_press[0];
        end
        rst = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tick();
            np += key_press[0];
        end
        rst = 1'b0;
        checks++;
        if (np !== 0 || key_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abandon: got %0d pulses level %b expected 0 0", np, key_level[0]);
        end
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (key_press[0]) begin np++; if (tp < 0) tp = t; end
        end
        checks++;
        if (np !== 1 || tp !== 10) begin
            errors++;
            $display("FAIL reset_mid_repress: got %0d pulses first at %0d expected 1 at 10", np, tp);
        end
        key[0] = 1'b1;
        for (int t = 0; t < 14; t++) tick();
    endtask

    task automatic test_repeat();
        int got[$];
        int exp_t[$];
        int nr = 0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        exp_t = '{10, 50, 60, 70, 80, 90, 100};
`else
        exp_t = '{10};
`endif
        key[1] = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (key_press[1]) got.push_back(t);
        end
        checks++;
        if (got.size() !== exp_t.size()) begin
            errors++;
            $display("FAIL repeat_count: got %0d pulses expected %0d", got.size(), exp_t.size());
        end else begin
            foreach (exp_t[i]) begin
                checks++;
                if (got[i] !== exp_t[i]) begin
                    errors++;
                    $display("FAIL repeat_time[%0d]: got %0d expected %0d", i, got[i], exp_t[i]);
                end
            end
        end
        key[1] = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            nr += key_release[1];
        end
        checks++;
        if (nr !== 1) begin
            errors++;
            $display("FAIL repeat_release: got %0d pulses expected 1", nr);
        end
    endtask

    task automatic test_glitch();
        int extra = 0, low = 0;
        key[2] = 1'b0;
        for (int t = 0; t < 15; t++) tick();
        key[2] = 1'b1;
        tick();
        extra += key_press[2] + key_release[2];
        low   += !key_level[2];
        key[2] = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            extra += key_press[2] + key_release[2];
            low   += !key_level[2];
        end
        checks++;
        if (extra !== 0 || low !== 0) begin
            errors++;
            $display("FAIL glitch_held: got %0d pulses %0d level-low clocks expected 0 0", extra, low);
        end
        key[2] = 1'b1;
        for (int t = 0; t < 14; t++) tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 800; cyc++) begin
            int p;
            p = ((cyc / 40) % 2 == 1) ? 25 : 3;
            for (int i = 0; i < NKEYS; i++)
                if ($urandom_range(p - 1) == 0) key[i] = ~key[i];
            rst = ($urandom_range(199) == 0);
            tick();
            checks++;
            if (key_level !== m_lvl) begin
                errors++;
                $display("FAIL rand_level: cycle %0d got %b expected %b", cyc, key_level, m_lvl);
            end
            checks++;
            if (key_press !== m_press) begin
                errors++;
                $display("FAIL rand_press: cycle %0d got %b expected %b", cyc, key_press, m_press);
            end
            checks++;
            if (key_release !== m_rel) begin
                errors++;
                $display("FAIL rand_release: cycle %0d got %b expected %b", cyc, key_release, m_rel);
            end
            checks++;
            if ((key_press & key_release) !== '0) begin
                errors++;
                $display("FAIL rand_exclusive: cycle %0d got %b expected 0", cyc, key_press & key_release);
            end
        end
        rst = 1'b0;
        key = '1;
        for (int t = 0; t < 14; t++) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        test_glitch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter NKEYS, default 4, number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, consecutive stable clocks required to accept a level change (5 ms at 50 MHz).
REQ-003 SHALL have parameter KEY_ACTIVE_LOW, default 1, 1 = raw key reads 0 when pressed.
REQ-004 SHALL have parameter REPEAT_DELAY, default 25000000, held clocks before first auto-repeat (used only with KEY_DEBOUNCE_REPEAT_EN).
REQ-005 SHALL have parameter REPEAT_PERIOD, default 5000000, clocks between auto-repeats (used only with KEY_DEBOUNCE_REPEAT_EN).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port key  input  NKEYS  raw asynchronous push-button inputs.
REQ-009 SHALL have port key_level  output  NKEYS  debounced level, 1 = pressed, polarity-normalised.
REQ-010 SHALL have port key_press  output  NKEYS  one-clock pulse per accepted press (and per repeat).
REQ-011 SHALL have port key_release  output  NKEYS  one-clock pulse per accepted release.

Function
REQ-012 Each channel SHALL pass key through a 2-flop synchroniser, then invert if KEY_ACTIVE_LOW=1.
REQ-013 Each channel SHALL run FSM RELEASED -> PRESS_WAIT -> HELD -> RELEASE_WAIT -> RELEASED.
REQ-014 RELEASED: synced=1 -> PRESS_WAIT, counter cleared; else stay.
REQ-015 PRESS_WAIT: synced=0 -> RELEASED (bounce, no pulse); counter reaching DEBOUNCE_CYCLES-1 with synced=1 -> HELD, key_level<=1, key_press<=1 for that one clock.
REQ-016 HELD: synced=0 -> RELEASE_WAIT, counter cleared.
REQ-017 RELEASE_WAIT: synced=1 -> HELD (no pulse); counter reaching DEBOUNCE_CYCLES-1 with synced=0 -> RELEASED, key_level<=0, key_release<=1 for one clock.
REQ-018 Latency raw edge to pulse SHALL be exactly 2 + DEBOUNCE_CYCLES clocks for a clean edge.
REQ-019 Counter width SHALL be $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)+1); counter SHALL saturate, never wrap.
REQ-020 All outputs SHALL be registered; key_press and key_release SHALL never be high in the same clock for one channel.
REQ-021 Channels SHALL be fully independent; simultaneous events on several keys SHALL each produce their own pulse in the same clock.

Reset
REQ-022 While rst=1: FSM=RELEASED, counters=0, key_level=0, key_press=0, key_release=0, synchronisers loaded with the released value (no spurious press on exit).
REQ-023 Reset mid-debounce SHALL abandon the pending transition with no pulse; a key still held after reset SHALL yield one key_press 2+DEBOUNCE_CYCLES clocks after rst falls.

Configuration
REQ-024 Macro KEY_DEBOUNCE_REPEAT_EN defined: in HELD, after REPEAT_DELAY clocks held, key_press SHALL pulse, then every REPEAT_PERIOD clocks until leaving HELD; RELEASE_WAIT suspends but does not reset the repeat counter only if returning to HELD, otherwise cleared.
REQ-025 Macro undefined: exactly one key_press per accepted press; repeat counter and parameters SHALL not generate logic.

Structure
REQ-026 Package key_debounce_pkg SHALL hold the FSM state typedef (2-bit enum) and default parameter constants.
REQ-027 Sub-module key_debounce_chan SHALL implement one channel (sync, FSM, counter, pulses); key_debounce SHALL instantiate NKEYS copies via generate.
REQ-028 key_press[3] SHALL be suitable as the clock-enable replacing the raw key[3] edge for the stored-operand register downstream.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10, KEY_ACTIVE_LOW=1)
REQ-029 key[0] 1->0 clean, held 30 clocks -> key_press[0] single pulse exactly 10 clocks after edge, key_level[0]=1; release -> key_release[0] 10 clocks later.
REQ-030 key[1] toggles every 3 clocks for 30 clocks then rests at 1 -> no pulses, key_level[1] stays 0.
REQ-031 key[2] and key[3] pressed same clock -> key_press[2] and key_press[3] high in the same clock.
REQ-032 key[0] pressed, rst asserted 5 clocks after edge for 2 clocks, key held -> no pulse before rst; exactly one key_press[0] 10 clocks after rst falls.
REQ-033 REPEAT_EN defined, key[1] held 100 clocks -> key_press[1] at clocks 10, 50, 60, 70, 80, 90, 100 after edge; undefined -> only at 10.
REQ-034 Glitch of 1-clock release during HELD -> no key_release, no extra key_press, key_level stays 1.
